// File: rtl/audio_sd_out_pkg.sv
// Shared definitions for the audio back-end: gain FSM encoding, gain limits
// and the saturating gain step used by the fade ramps.
package audio_sd_out_pkg;

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      PLAY      = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   localparam logic [3:0] GAIN_MAX       = 4'd15;
   localparam int         SAMPLE_RATE_HZ = 16384;

   // One gain step toward GAIN_MAX (up=1) or toward zero (up=0), never wrapping.
   function automatic logic [3:0] gain_step(input logic [3:0] g, input logic up);
      logic [3:0] r;
      r = g;
      if (up) begin
         if (g != GAIN_MAX) r = g + 4'd1;
      end else begin
         if (g != 4'd0) r = g - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/audio_sd_out_sd_dac8.sv
// 8-bit first-order sigma-delta modulator: the accumulator carry is the
// registered bitstream; clear holds both accumulator and output at zero.
module sd_dac8 (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic [7:0] din,
   output logic       dout
);

   logic [7:0] acc_q, acc_d;
   logic       dout_q, dout_d;
   logic [8:0] sum;

   always_comb begin
      sum    = {1'b0, acc_q} + {1'b0, din};
      acc_d  = sum[7:0];
      dout_d = sum[8];
      if (clear) begin
         acc_d  = 8'd0;
         dout_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q  <= 8'd0;
         dout_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/audio_sd_out.sv
// Audio back-end: sample-rate strobe, post-strobe sample capture, fade gain
// ramp FSM and the sigma-delta output stage.
module audio_sd_out
   import audio_sd_out_pkg::*;
#(
   parameter int CLOCK_DIV    = 1536,
   parameter int RAMP_SAMPLES = 256
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] sample,
   output logic       sample_ena,
   output logic       audio_out,
   output logic       active,
   output logic       muted
);

   localparam logic [15:0] DIV_LAST  = 16'(CLOCK_DIV - 1);
   localparam logic [15:0] RAMP_LAST = 16'(RAMP_SAMPLES - 1);

   logic [15:0] div_cnt_q, div_cnt_d;
   logic        sample_ena_q, sample_ena_d;
   logic        cap_ena_q, cap_ena_d;
   logic [3:0]  held_q, held_d;
   logic [3:0]  gain_q, gain_d;
   logic [15:0] ramp_cnt_q, ramp_cnt_d;
   state_t      state_q, state_d;
   logic [3:0]  next_gain;
   logic [7:0]  scaled;

   // Divider and capture: the generator updates on the strobe edge, so its
   // settled value is taken one clock later on cap_ena.
   always_comb begin
      div_cnt_d    = (div_cnt_q == DIV_LAST) ? 16'd0 : div_cnt_q + 16'd1;
      sample_ena_d = (div_cnt_q == DIV_LAST);
      cap_ena_d    = sample_ena_q;
      held_d       = cap_ena_q ? sample : held_q;
   end

   // Direction changes are checked before the ramp step so they always win.
   always_comb begin
      state_d    = state_q;
      gain_d     = gain_q;
      ramp_cnt_d = ramp_cnt_q;
      next_gain  = gain_q;
      case (state_q)
         MUTED: begin
            if (enable) begin
               state_d    = RAMP_UP;
               ramp_cnt_d = 16'd0;
            end
         end
         RAMP_UP: begin
            if (!enable) begin
               state_d    = RAMP_DOWN;
               ramp_cnt_d = 16'd0;
            end else if (cap_ena_q) begin
               if (ramp_cnt_q == RAMP_LAST) begin
                  ramp_cnt_d = 16'd0;
                  next_gain  = gain_step(gain_q, 1'b1);
                  gain_d     = next_gain;
                  if (next_gain == GAIN_MAX) state_d = PLAY;
               end else begin
                  ramp_cnt_d = ramp_cnt_q + 16'd1;
               end
            end
         end
         PLAY: begin
            if (!enable) begin
               state_d    = RAMP_DOWN;
               ramp_cnt_d = 16'd0;
            end
         end
         RAMP_DOWN: begin
            if (enable) begin
               state_d    = RAMP_UP;
               ramp_cnt_d = 16'd0;
            end else if (cap_ena_q) begin
               if (ramp_cnt_q == RAMP_LAST) begin
                  ramp_cnt_d = 16'd0;
                  next_gain  = gain_step(gain_q, 1'b0);
                  gain_d     = next_gain;
                  if (next_gain == 4'd0) state_d = MUTED;
               end else begin
                  ramp_cnt_d = ramp_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = MUTED;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt_q    <= 16'd0;
         sample_ena_q <= 1'b0;
         cap_ena_q    <= 1'b0;
         held_q       <= 4'd0;
         gain_q       <= 4'd0;
         ramp_cnt_q   <= 16'd0;
         state_q      <= MUTED;
      end else begin
         div_cnt_q    <= div_cnt_d;
         sample_ena_q <= sample_ena_d;
         cap_ena_q    <= cap_ena_d;
         held_q       <= held_d;
         gain_q       <= gain_d;
         ramp_cnt_q   <= ramp_cnt_d;
         state_q      <= state_d;
      end
   end

   assign scaled = {4'd0, held_q} * {4'd0, gain_q};

   // Clearing on the next state keeps the pin low for every clock spent in MUTED.
   sd_dac8 u_dac (
      .clock (clock),
      .reset (reset),
      .clear (state_d == MUTED),
      .din   (scaled),
      .dout  (audio_out)
   );

   assign sample_ena = sample_ena_q;
   assign active     = (state_q == PLAY);
   assign muted      = (state_q == MUTED);

endmodule

// File: tb/tb_audio_sd_out.sv
// Directed bench for audio_sd_out with CLOCK_DIV=8 and RAMP_SAMPLES=2.
module tb_audio_sd_out;
   import audio_sd_out_pkg::*;

   localparam int CD = 8;
   localparam int RS = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] sample = 4'd0;
   logic       sample_ena, audio_out, active, muted;

   int checks = 0;
   int errors = 0;

   audio_sd_out #(.CLOCK_DIV(CD), .RAMP_SAMPLES(RS)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .sample     (sample),
      .sample_ena (sample_ena),
      .audio_out  (audio_out),
      .active     (active),
      .muted      (muted)
   );

   always #5 clock = ~clock;

   task automatic test_reset;
      reset = 1'b1;
      @(posedge clock); #1;
      checks++; if (sample_ena !== 1'b0) begin errors++; $display("FAIL reset_sample_ena got %b expected 0", sample_ena); end
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL reset_audio_out got %b expected 0", audio_out); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b expected 0", active); end
      checks++; if (muted !== 1'b1) begin errors++; $display("FAIL reset_muted got %b expected 1", muted); end
      checks++; if (dut.gain_q !== 4'd0) begin errors++; $display("FAIL reset_gain got %0d expected 0", dut.gain_q); end
      checks++; if (dut.div_cnt_q !== 16'd0) begin errors++; $display("FAIL reset_div_cnt got %0d expected 0", dut.div_cnt_q); end
      checks++; if (dut.held_q !== 4'd0) begin errors++; $display("FAIL reset_held got %0d expected 0", dut.held_q); end
   endtask

   task automatic test_strobe;
      logic exp;
      @(negedge clock) reset = 1'b0;
      for (int n = 1; n <= 3 * CD; n++) begin
         @(posedge clock); #1;
         exp = ((n % CD) == 0);
         checks++; if (sample_ena !== exp) begin errors++; $display("FAIL strobe_clk%0d got %b expected %b", n, sample_ena, exp); end
         checks++; if (muted !== 1'b1) begin errors++; $display("FAIL strobe_muted_clk%0d got %b expected 1", n, muted); end
         checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL strobe_audio_clk%0d got %b expected 0", n, audio_out); end
      end
   endtask

   task automatic test_capture;
      int cyc;
      cyc = 0;
      while (sample_ena !== 1'b1 && cyc < 2 * CD) begin
         @(posedge clock); #1; cyc++;
      end
      checks++; if (sample_ena !== 1'b1) begin errors++; $display("FAIL capture_wait_strobe got %b expected 1", sample_ena); end
      sample = 4'd5;
      @(posedge clock); #1;
      checks++; if (dut.held_q !== 4'd0) begin errors++; $display("FAIL capture_early got %0d expected 0", dut.held_q); end
      @(posedge clock); #1;
      checks++; if (dut.held_q !== 4'd5) begin errors++; $display("FAIL capture_held got %0d expected 5", dut.held_q); end
      @(negedge clock) sample = 4'd9;
      @(negedge clock) sample = 4'd5;
      checks++; if (dut.held_q !== 4'd5) begin errors++; $display("FAIL capture_glitch got %0d expected 5", dut.held_q); end
      repeat (2 * CD) @(posedge clock);
      #1;
      checks++; if (dut.held_q !== 4'd5) begin errors++; $display("FAIL capture_stable got %0d expected 5", dut.held_q); end
   endtask

   task automatic test_fade_in;
      int cyc, last, k, ones;
      logic [3:0] prev;
      sample = 4'hF;
      @(negedge clock) enable = 1'b1;
      @(posedge clock); #1;
      checks++; if (dut.state_q !== RAMP_UP) begin errors++; $display("FAIL fadein_state got %0d expected %0d", dut.state_q, RAMP_UP); end
      checks++; if (dut.ramp_cnt_q !== 16'd0) begin errors++; $display("FAIL fadein_ramp_cnt got %0d expected 0", dut.ramp_cnt_q); end
      prev = 4'd0; last = 0; cyc = 0; k = 0;
      while (k < 15 && cyc < 400) begin
         @(posedge clock); #1; cyc++;
         if (dut.gain_q !== prev) begin
            k++;
            checks++; if (dut.gain_q !== 4'(k)) begin errors++; $display("FAIL fadein_gain got %0d expected %0d", dut.gain_q, k); end
            if (k >= 2) begin
               checks++; if (cyc - last != CD * RS) begin errors++; $display("FAIL fadein_interval step%0d got %0d expected %0d", k, cyc - last, CD * RS); end
            end
            last = cyc;
            prev = dut.gain_q;
         end
      end
      checks++; if (k != 15) begin errors++; $display("FAIL fadein_timeout got %0d steps expected 15", k); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL fadein_active got %b expected 1", active); end
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clock); #1;
         if (audio_out === 1'b1) ones++;
      end
      checks++; if (ones != 225) begin errors++; $display("FAIL fadein_density got %0d expected 225", ones); end
   endtask

   task automatic test_fade_out;
      int cyc, last, k, ones;
      logic [3:0] prev;
      @(negedge clock) enable = 1'b0;
      @(posedge clock); #1;
      checks++; if (dut.state_q !== RAMP_DOWN) begin errors++; $display("FAIL fadeout_state got %0d expected %0d", dut.state_q, RAMP_DOWN); end
      checks++; if (dut.gain_q !== 4'd15) begin errors++; $display("FAIL fadeout_gain_start got %0d expected 15", dut.gain_q); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL fadeout_active got %b expected 0", active); end
      prev = 4'd15; last = 0; cyc = 0; k = 15;
      while (k > 0 && cyc < 400) begin
         @(posedge clock); #1; cyc++;
         if (dut.gain_q !== prev) begin
            k--;
            checks++; if (dut.gain_q !== 4'(k)) begin errors++; $display("FAIL fadeout_gain got %0d expected %0d", dut.gain_q, k); end
            if (k <= 13) begin
               checks++; if (cyc - last != CD * RS) begin errors++; $display("FAIL fadeout_interval step%0d got %0d expected %0d", k, cyc - last, CD * RS); end
            end
            last = cyc;
            prev = dut.gain_q;
         end
      end
      checks++; if (k != 0) begin errors++; $display("FAIL fadeout_timeout got gain %0d expected 0", k); end
      checks++; if (muted !== 1'b1) begin errors++; $display("FAIL fadeout_muted got %b expected 1", muted); end
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL fadeout_audio got %b expected 0", audio_out); end
      ones = 0;
      for (int i = 0; i < 32; i++) begin
         @(posedge clock); #1;
         if (audio_out !== 1'b0) ones++;
      end
      checks++; if (ones != 0) begin errors++; $display("FAIL fadeout_silence got %0d ones expected 0", ones); end
   endtask

   task automatic test_reversal;
      int cyc;
      @(negedge clock) enable = 1'b1;
      cyc = 0;
      while (dut.gain_q !== 4'd7 && cyc < 300) begin
         @(posedge clock); #1; cyc++;
      end
      checks++; if (dut.gain_q !== 4'd7) begin errors++; $display("FAIL rev_reach7 got %0d expected 7", dut.gain_q); end
      @(negedge clock) enable = 1'b0;
      @(posedge clock); #1;
      checks++; if (dut.state_q !== RAMP_DOWN) begin errors++; $display("FAIL rev_down_state got %0d expected %0d", dut.state_q, RAMP_DOWN); end
      checks++; if (dut.ramp_cnt_q !== 16'd0) begin errors++; $display("FAIL rev_down_ramp_cnt got %0d expected 0", dut.ramp_cnt_q); end
      @(posedge clock);
      @(posedge clock);
      @(negedge clock) enable = 1'b1;
      @(posedge clock); #1;
      checks++; if (dut.state_q !== RAMP_UP) begin errors++; $display("FAIL rev_up_state got %0d expected %0d", dut.state_q, RAMP_UP); end
      checks++; if (dut.gain_q !== 4'd7) begin errors++; $display("FAIL rev_gain_kept got %0d expected 7", dut.gain_q); end
      checks++; if (dut.ramp_cnt_q !== 16'd0) begin errors++; $display("FAIL rev_up_ramp_cnt got %0d expected 0", dut.ramp_cnt_q); end
      cyc = 0;
      while (active !== 1'b1 && cyc < 300) begin
         @(posedge clock); #1; cyc++;
      end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL rev_play got %b expected 1", active); end
      checks++; if (dut.gain_q !== 4'd15) begin errors++; $display("FAIL rev_final_gain got %0d expected 15", dut.gain_q); end
   endtask

   task automatic test_reset_mid_ramp;
      int cyc;
      logic exp;
      @(negedge clock) enable = 1'b0;
      cyc = 0;
      while (dut.gain_q !== 4'd9 && cyc < 300) begin
         @(posedge clock); #1; cyc++;
      end
      checks++; if (dut.gain_q !== 4'd9) begin errors++; $display("FAIL rst_reach9 got %0d expected 9", dut.gain_q); end
      #2 reset = 1'b1;
      #1;
      checks++; if (dut.gain_q !== 4'd0) begin errors++; $display("FAIL rst_gain got %0d expected 0", dut.gain_q); end
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL rst_audio got %b expected 0", audio_out); end
      checks++; if (muted !== 1'b1) begin errors++; $display("FAIL rst_muted got %b expected 1", muted); end
      checks++; if (dut.div_cnt_q !== 16'd0) begin errors++; $display("FAIL rst_div_cnt got %0d expected 0", dut.div_cnt_q); end
      @(negedge clock);
      @(negedge clock) reset = 1'b0;
      for (int n = 1; n <= CD; n++) begin
         @(posedge clock); #1;
         exp = (n == CD);
         checks++; if (sample_ena !== exp) begin errors++; $display("FAIL rst_strobe_clk%0d got %b expected %b", n, sample_ena, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_strobe();
      test_capture();
      test_fade_in();
      test_fade_out();
      test_reversal();
      test_reset_mid_ramp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
